// File: rtl/ccsds_turbo_dec_rp_sched.sv
// Half-iteration scheduler for the CCSDS turbo SISO: sequences the forward (alpha)
// and backward (beta) recursions over one trellis block and flags completion.
//
// state | meaning
// IDLE  | waiting for istart
// CLR_F | alpha-processor state clear
// FWD   | forward pass, step counter 0..L-1
// CLR_B | beta-processor state clear (last alpha write lands here)
// BWD   | backward pass, step counter L-1..0
// FLUSH | last extrinsic valid drains, odone follows
module ccsds_turbo_dec_rp_sched #(
    parameter int pADDR_W = 14
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               istart,
    input  logic               iabort,
    input  logic [1:0]         icode,
    input  logic [pADDR_W-1:0] ilen,
    output logic [1:0]         ocode,
    output logic               ofwd_state_clr,
    output logic               ofwd_val,
    output logic [pADDR_W-1:0] ofwd_addr,
    output logic               oalpha_we,
    output logic [pADDR_W-1:0] oalpha_waddr,
    output logic               obwd_state_clr,
    output logic               obwd_val,
    output logic [pADDR_W-1:0] obwd_addr,
    output logic               oext_val,
    output logic [pADDR_W-1:0] oext_addr,
    output logic               obusy,
    output logic               odone
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR_F = 3'd1,
        FWD   = 3'd2,
        CLR_B = 3'd3,
        BWD   = 3'd4,
        FLUSH = 3'd5
    } state_t;

    localparam logic [pADDR_W-1:0] ONE = pADDR_W'(1);

    state_t             state_q, state_d;
    logic [pADDR_W-1:0] cnt_q, cnt_d;
    logic [pADDR_W-1:0] len_q, len_d;
    logic [1:0]         code_d;
    logic               done_d;
    logic               busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        code_d  = ocode;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // obusy still covers the odone cycle, so no restart there
                if (istart && !obusy) begin
                    code_d  = icode;
                    len_d   = ilen;
                    state_d = (ilen == '0) ? FLUSH : CLR_F;
                end
            end
            CLR_F: begin
                cnt_d   = '0;
                state_d = FWD;
            end
            FWD: begin
                if (cnt_q == len_q - ONE) state_d = CLR_B;
                else                      cnt_d   = cnt_q + ONE;
            end
            CLR_B: begin
                cnt_d   = len_q - ONE;
                state_d = BWD;
            end
            BWD: begin
                if (cnt_q == '0) state_d = FLUSH;
                else             cnt_d   = cnt_q - ONE;
            end
            FLUSH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (iabort) begin
            state_d = IDLE;
            done_d  = 1'b0;
            code_d  = ocode;
        end
        busy_d = (state_d != IDLE) || done_d;
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            len_q          <= '0;
            ocode          <= '0;
            ofwd_state_clr <= 1'b0;
            ofwd_val       <= 1'b0;
            ofwd_addr      <= '0;
            oalpha_we      <= 1'b0;
            oalpha_waddr   <= '0;
            obwd_state_clr <= 1'b0;
            obwd_val       <= 1'b0;
            obwd_addr      <= '0;
            oext_val       <= 1'b0;
            oext_addr      <= '0;
            obusy          <= 1'b0;
            odone          <= 1'b0;
        end else if (iclkena) begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            len_q          <= len_d;
            ocode          <= code_d;
            ofwd_state_clr <= (state_d == CLR_F);
            ofwd_val       <= (state_d == FWD);
            if (state_d == FWD) ofwd_addr <= cnt_d;
            oalpha_we      <= ofwd_val && !iabort;
            oalpha_waddr   <= ofwd_addr;
            obwd_state_clr <= (state_d == CLR_B);
            obwd_val       <= (state_d == BWD);
            if (state_d == BWD) obwd_addr <= cnt_d;
            oext_val       <= obwd_val && !iabort;
            oext_addr      <= obwd_addr;
            obusy          <= busy_d;
            odone          <= done_d;
        end
    end

endmodule

// File: tb/tb_ccsds_turbo_dec_rp_sched.sv
// Bench for ccsds_turbo_dec_rp_sched: per-block schedules from the timing table,
// queued per cycle and compared on the falling clock edge.
module tb_ccsds_turbo_dec_rp_sched;

    localparam int AW = 14;

    logic          iclk = 1'b0;
    logic          ireset, iclkena, istart, iabort;
    logic [1:0]    icode;
    logic [AW-1:0] ilen;
    logic [1:0]    ocode;
    logic          ofwd_state_clr, ofwd_val, oalpha_we;
    logic          obwd_state_clr, obwd_val, oext_val, obusy, odone;
    logic [AW-1:0] ofwd_addr, oalpha_waddr, obwd_addr, oext_addr;

    ccsds_turbo_dec_rp_sched #(.pADDR_W(AW)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .istart(istart),
        .iabort(iabort), .icode(icode), .ilen(ilen), .ocode(ocode),
        .ofwd_state_clr(ofwd_state_clr), .ofwd_val(ofwd_val), .ofwd_addr(ofwd_addr),
        .oalpha_we(oalpha_we), .oalpha_waddr(oalpha_waddr),
        .obwd_state_clr(obwd_state_clr), .obwd_val(obwd_val), .obwd_addr(obwd_addr),
        .oext_val(oext_val), .oext_addr(oext_addr), .obusy(obusy), .odone(odone)
    );

    always #5 iclk = ~iclk;

    typedef struct packed {
        logic [1:0]    code;
        logic          fclr;
        logic          fval;
        logic [AW-1:0] faddr;
        logic          awe;
        logic [AW-1:0] awaddr;
        logic          bclr;
        logic          bval;
        logic [AW-1:0] baddr;
        logic          ev;
        logic [AW-1:0] eaddr;
        logic          busy;
        logic          done;
    } out_t;

    typedef struct {
        int   vi;
        int   k;
        out_t o;
    } exp_t;

    // sp1/sp2: spurious istart edges; stall_k: cycle after which iclkena drops
    // for stall_n edges; abort_k: edge sampling iabort; stop_k: end run early
    typedef struct {
        int len;
        int code;
        int sp1;
        int sp2;
        int stall_k;
        int stall_n;
        int abort_k;
        int stop_k;
    } vec_t;

    exp_t exp_q[$];
    exp_t cur_e;
    out_t cur_a;
    event chk_ev;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[9];

    function automatic out_t model(int k, vec_t v);
        out_t e;
        int   L;
        int   dk;
        e      = '0;
        L      = v.len;
        dk     = (L > 0) ? 2 * L + 4 : 2;
        e.code = 2'(v.code);
        if (v.abort_k > 0 && k > v.abort_k) return e;
        if (L > 0) begin
            e.fclr = (k == 1);
            if (k >= 2 && k <= L + 1) begin e.fval = 1'b1; e.faddr = AW'(k - 2); end
            if (k >= 3 && k <= L + 2) begin e.awe = 1'b1; e.awaddr = AW'(k - 3); end
            e.bclr = (k == L + 2);
            if (k >= L + 3 && k <= 2 * L + 2) begin e.bval = 1'b1; e.baddr = AW'(2 * L + 2 - k); end
            if (k >= L + 4 && k <= 2 * L + 3) begin e.ev = 1'b1; e.eaddr = AW'(2 * L + 3 - k); end
        end
        e.done = (k == dk);
        e.busy = (k >= 1 && k <= dk);
        return e;
    endfunction

    always begin
        @(negedge iclk or chk_ev);
        while (exp_q.size() > 0) begin
            cur_e = exp_q.pop_front();
            cur_a = '{ocode, ofwd_state_clr, ofwd_val, ofwd_addr, oalpha_we, oalpha_waddr,
                      obwd_state_clr, obwd_val, obwd_addr, oext_val, oext_addr, obusy, odone};
            n_vec++;
            if (cur_a.code != cur_e.o.code || cur_a.fclr != cur_e.o.fclr ||
                cur_a.fval != cur_e.o.fval || (cur_e.o.fval && cur_a.faddr != cur_e.o.faddr) ||
                cur_a.awe != cur_e.o.awe || (cur_e.o.awe && cur_a.awaddr != cur_e.o.awaddr) ||
                cur_a.bclr != cur_e.o.bclr || cur_a.bval != cur_e.o.bval ||
                (cur_e.o.bval && cur_a.baddr != cur_e.o.baddr) ||
                cur_a.ev != cur_e.o.ev || (cur_e.o.ev && cur_a.eaddr != cur_e.o.eaddr) ||
                cur_a.busy != cur_e.o.busy || cur_a.done != cur_e.o.done) begin
                n_err++;
                $display("FAIL sched vec%0d cyc%0d outputs act=%h exp=%h",
                         cur_e.vi, cur_e.k, cur_a, cur_e.o);
            end
        end
    end

    task automatic run_vec(int vi, vec_t v);
        int   k;
        int   stalls;
        int   steps;
        int   end_k;
        logic en;
        k      = 0;
        stalls = 0;
        steps  = 0;
        if (v.stop_k > 0)       end_k = v.stop_k;
        else if (v.abort_k > 0) end_k = v.abort_k + 1;
        else                    end_k = ((v.len > 0) ? 2 * v.len + 4 : 2) + 1;
        while (k < end_k && steps < 500) begin
            @(negedge iclk);
            #1;
            en = !(v.stall_k > 0 && k == v.stall_k + 1 && stalls < v.stall_n);
            if (!en) stalls++;
            iclkena = en;
            istart  = en && (k == 0 || k == v.sp1 || k == v.sp2);
            iabort  = en && v.abort_k > 0 && k == v.abort_k;
            if (k == 0) begin
                ilen  = AW'(v.len);
                icode = 2'(v.code);
            end else begin
                ilen  = AW'($urandom);
                icode = 2'($urandom);
            end
            if (en) k++;
            exp_q.push_back('{vi, k, model(k, v)});
            steps++;
        end
        @(negedge iclk);
        #1;
        istart = 1'b0;
        iabort = 1'b0;
        iclkena = 1'b1;
    endtask

    initial begin
        ireset  = 1'b1;
        iclkena = 1'b1;
        istart  = 1'b0;
        iabort  = 1'b0;
        icode   = 2'd0;
        ilen    = '0;
        vecs[0] = '{4, 1, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{1, 2, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{0, 2, 0, 0, 0, 0, 0, 0};
        vecs[3] = '{4, 3, 3, 8, 0, 0, 0, 0};
        vecs[4] = '{4, 1, 0, 0, 3, 3, 0, 0};
        vecs[5] = '{4, 2, 0, 0, 0, 0, 7, 0};
        vecs[6] = '{4, 0, 0, 0, 0, 0, 0, 0};
        vecs[7] = '{9, 3, 0, 0, 0, 0, 0, 0};
        vecs[8] = '{6, 2, 0, 0, 0, 0, 0, 5};

        #2;
        exp_q.push_back('{-1, 0, out_t'('0)});
        ->chk_ev;
        #20;
        ireset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // asynchronous reset in the middle of a block, well away from any clock edge
        ireset = 1'b1;
        #1;
        exp_q.push_back('{-2, 0, out_t'('0)});
        ->chk_ev;
        #1;
        @(negedge iclk);
        #1;
        ireset = 1'b0;

        run_vec(9, vecs[0]);

        @(negedge iclk);
        #1;
        if (n_vec < 12) begin
            n_err++;
            $display("FAIL bench vector count act=%0d exp>=12", n_vec);
        end
        if (n_err != 0)
            $display("FAIL summary miscompares act=%0d exp=0", n_err);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not complete act=running exp=finished");
        $fatal(1);
    end

endmodule
